// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit controller: access sizes, FSM states,
// the in-flight tag layout and small address helpers.
package lsu_ctrl_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } lsu_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FULL = 2'd2,
      ERR  = 2'd3
   } lsu_state_e;

   typedef struct packed {
      logic [1:0] addr;
      lsu_size_e  size;
      logic       sgn;
      logic       wen;
   } lsu_tag_s;

   function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] lo);
      case (size)
         BYTE:    return 1'b0;
         HALF:    return lo[0];
         default: return lo != 2'b00;
      endcase
   endfunction

   // Low address bits after forcing natural alignment for the access size.
   function automatic logic [1:0] align_lo(input lsu_size_e size, input logic [1:0] lo);
      case (size)
         BYTE:    return lo;
         HALF:    return {lo[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/lsu_ctrl_tag_fifo.sv
// In-order FIFO of tags for memory operations issued but not yet retired.
module lsu_tag_fifo
   import lsu_ctrl_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  lsu_tag_s push_tag,
   input  logic     pop,
   output lsu_tag_s head,
   output logic     full,
   output logic     empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   lsu_tag_s         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end

   // NOTE: the storage array is not reset; the count and pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_tag;
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one-entry request hold register, in-order tag FIFO,
// load lane formatting. Define LSU_MISALIGN_EXC_EN to trap misaligned accesses instead of truncating.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MAX_OUT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid_i,
   input  logic              req_wen_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_signed_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              req_yumi_o,
   input  logic              commit_ok_i,
   output logic              rd_valid_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              stall_o,
   output logic              exc_o,
   output logic              mem_valid_o,
   output logic              mem_wen_o,
   output logic [1:0]        mem_size_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_yumi_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              mem_ryumi_o
);

   localparam int               CNT_W   = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

   lsu_size_e         req_size;
   logic              misalign;
   logic              can_take;
   logic              exc_set;
   logic              push;
   logic [DATA_W-1:0] wdata_rep;

   logic              hold_v;
   logic              hold_wen;
   logic              hold_sgn;
   lsu_size_e         hold_size;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_wdata;

   logic [CNT_W-1:0]  out_cnt;
   logic [CNT_W-1:0]  cnt_next;
   logic              exc_q;
   lsu_state_e        state;
   lsu_state_e        state_next;

   lsu_tag_s          head_tag;
   logic              fifo_full;
   logic              fifo_empty;
   logic [7:0]        byte_lane;
   logic [15:0]       half_lane;

   assign req_size = lsu_size_e'(req_size_i);

`ifdef LSU_MISALIGN_EXC_EN
   assign misalign = is_misaligned(req_size, req_addr_i[1:0]);
`else
   assign misalign = 1'b0;
`endif

   assign can_take   = req_valid_i & ~hold_v & (out_cnt < MAX_CNT) & ~exc_q;
   assign req_yumi_o = can_take & ~misalign;
   assign exc_set    = can_take & misalign;
   assign push       = mem_yumi_i & hold_v & ~fifo_full;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      wdata_rep = req_wdata_i;
      case (req_size)
         BYTE:    wdata_rep = {(DATA_W / 8){req_wdata_i[7:0]}};
         HALF:    wdata_rep = {(DATA_W / 16){req_wdata_i[15:0]}};
         default: wdata_rep = req_wdata_i;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_v <= 1'b0;
      end else if (req_yumi_o) begin
         hold_v     <= 1'b1;
         hold_wen   <= req_wen_i;
         hold_sgn   <= req_signed_i;
         hold_size  <= req_size;
         hold_addr  <= {req_addr_i[ADDR_W-1:2], align_lo(req_size, req_addr_i[1:0])};
         hold_wdata <= wdata_rep;
      end else if (push) begin
         hold_v <= 1'b0;
      end
   end

   assign mem_valid_o = hold_v;
   assign mem_wen_o   = hold_wen;
   assign mem_size_o  = hold_size;
   assign mem_addr_o  = hold_addr;
   assign mem_wdata_o = hold_wdata;

   lsu_tag_fifo #(.DEPTH(MAX_OUT)) u_tag_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_tag ('{addr: hold_addr[1:0], size: hold_size, sgn: hold_sgn, wen: hold_wen}),
      .pop      (mem_ryumi_o),
      .head     (head_tag),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign mem_ryumi_o = mem_rvalid_i & commit_ok_i & ~fifo_empty;
   assign rd_valid_o  = mem_ryumi_o;
   assign byte_lane   = mem_rdata_i[{head_tag.addr, 3'b000} +: 8];
   assign half_lane   = mem_rdata_i[{head_tag.addr[1], 4'b0000} +: 16];

   always_comb begin
      rd_data_o = '0;
      if (mem_ryumi_o && !head_tag.wen) begin
         case (head_tag.size)
            BYTE:    rd_data_o = {{(DATA_W - 8){head_tag.sgn & byte_lane[7]}}, byte_lane};
            HALF:    rd_data_o = {{(DATA_W - 16){head_tag.sgn & half_lane[15]}}, half_lane};
            default: rd_data_o = mem_rdata_i;
         endcase
      end
   end

   always_comb begin
      cnt_next = out_cnt;
      if (req_yumi_o && !mem_ryumi_o)      cnt_next = out_cnt + CNT_W'(1);
      else if (!req_yumi_o && mem_ryumi_o) cnt_next = out_cnt - CNT_W'(1);
   end

   always_comb begin
      state_next = state;
      if (state == ERR || exc_set)   state_next = ERR;
      else if (cnt_next == '0)       state_next = IDLE;
      else if (cnt_next == MAX_CNT)  state_next = FULL;
      else                           state_next = BUSY;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_cnt <= '0;
         exc_q   <= 1'b0;
         state   <= IDLE;
      end else begin
         out_cnt <= cnt_next;
         state   <= state_next;
         if (exc_set) exc_q <= 1'b1;
      end
   end

   assign exc_o   = exc_q;
   assign stall_o = (req_valid_i & ~req_yumi_o)
                  | ((out_cnt != '0) & ~((out_cnt == CNT_W'(1)) & mem_ryumi_o));

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_lsu_ctrl;
   import lsu_ctrl_pkg::*;

   localparam int MAX_OUT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_wen_i = 1'b0;
   logic [1:0]  req_size_i = 2'd0;
   logic        req_signed_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        req_yumi_o;
   logic        commit_ok_i = 1'b1;
   logic        rd_valid_o;
   logic [31:0] rd_data_o;
   logic        stall_o;
   logic        exc_o;
   logic        mem_valid_o;
   logic        mem_wen_o;
   logic [1:0]  mem_size_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_yumi_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_ryumi_o;

   lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(MAX_OUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid_i  (req_valid_i),
      .req_wen_i    (req_wen_i),
      .req_size_i   (req_size_i),
      .req_signed_i (req_signed_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .req_yumi_o   (req_yumi_o),
      .commit_ok_i  (commit_ok_i),
      .rd_valid_o   (rd_valid_o),
      .rd_data_o    (rd_data_o),
      .stall_o      (stall_o),
      .exc_o        (exc_o),
      .mem_valid_o  (mem_valid_o),
      .mem_wen_o    (mem_wen_o),
      .mem_size_o   (mem_size_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_yumi_i   (mem_yumi_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .mem_ryumi_o  (mem_ryumi_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: an operation is either in the hold slot or queued awaiting its response.
   typedef struct {
      logic [1:0] lo;
      logic [1:0] size;
      bit         sgn;
      bit         wen;
   } mtag_t;

   mtag_t       mq[$];
   bit          m_hold_v;
   mtag_t       m_hold;
   logic [31:0] m_hold_addr;
   logic [31:0] m_hold_wdata;
   bit          m_exc;

   bit          e_yumi, e_exc_set, e_ryumi;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] nbytes(input logic [1:0] s);
      return (s == 2'd0) ? 32'd1 : (s == 2'd1) ? 32'd2 : 32'd4;
   endfunction

   function automatic bit model_misaligned(input logic [1:0] s, input logic [31:0] a);
      return (a % nbytes(s)) != 0;
   endfunction

   function automatic logic [31:0] fmt_load(input mtag_t t, input logic [31:0] r);
      logic [31:0] n, v, mask;
      n = nbytes(t.size);
      if (n == 32'd4) return r;
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = (r >> (8 * t.lo)) & mask;
      if (t.sgn && v[8 * n - 1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [31:0] replicate(input logic [1:0] s, input logic [31:0] wd);
      case (nbytes(s))
         32'd1:   return (wd & 32'hFF) * 32'h01010101;
         32'd2:   return (wd & 32'hFFFF) * 32'h00010001;
         default: return wd;
      endcase
   endfunction

   task automatic model_clear();
      mq.delete();
      m_hold_v = 1'b0;
      m_exc    = 1'b0;
   endtask

   // Compare every observable output against the model, away from the rising edge.
   task automatic sample();
      int          cnt;
      bit          take, mis;
      bit          e_stall;
      logic [31:0] e_rd;
      lsu_state_e  e_state;
      @(negedge clk);
      cnt = int'(m_hold_v) + mq.size();
      mis = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
      mis = model_misaligned(req_size_i, req_addr_i);
`endif
      take      = req_valid_i && !m_hold_v && cnt < MAX_OUT && !m_exc;
      e_yumi    = take && !mis;
      e_exc_set = take && mis;
      e_ryumi   = mem_rvalid_i && commit_ok_i && mq.size() > 0;
      e_rd      = (e_ryumi && !mq[0].wen) ? fmt_load(mq[0], mem_rdata_i) : 32'd0;
      e_stall   = (req_valid_i && !e_yumi) || (cnt != 0 && !(cnt == 1 && e_ryumi));
      e_state   = m_exc ? ERR : (cnt == 0) ? IDLE : (cnt == MAX_OUT) ? FULL : BUSY;
      check("req_yumi", req_yumi_o, e_yumi);
      check("mem_valid", mem_valid_o, m_hold_v);
      if (m_hold_v) begin
         check("mem_wen", mem_wen_o, m_hold.wen);
         check("mem_size", mem_size_o, m_hold.size);
         check("mem_addr", mem_addr_o, m_hold_addr);
         check("mem_wdata", mem_wdata_o, m_hold_wdata);
      end
      check("mem_ryumi", mem_ryumi_o, e_ryumi);
      check("rd_valid", rd_valid_o, e_ryumi);
      check("rd_data", rd_data_o, e_rd);
      check("stall", stall_o, e_stall);
      check("exc", exc_o, m_exc);
      check("state", 64'(dut.state), 64'(e_state));
      check("out_cnt", 64'(dut.out_cnt), 64'(cnt));
   endtask

   task automatic advance();
      logic [31:0] nb;
      @(posedge clk);
      if (!reset) begin
         model_clear();
      end else begin
         if (e_ryumi) void'(mq.pop_front());
         if (mem_yumi_i && m_hold_v) begin
            mq.push_back(m_hold);
            m_hold_v = 1'b0;
         end
         if (e_yumi) begin
            nb           = nbytes(req_size_i);
            m_hold_v     = 1'b1;
            m_hold_addr  = req_addr_i & ~(nb - 32'd1);
            m_hold_wdata = replicate(req_size_i, req_wdata_i);
            m_hold       = '{lo: m_hold_addr[1:0], size: req_size_i, sgn: req_signed_i, wen: req_wen_i};
         end
         if (e_exc_set) m_exc = 1'b1;
      end
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      repeat (n) @(posedge clk);
      model_clear();
      #1;
      reset = 1'b1;
   endtask

   task automatic drive_req(input logic v, input logic wen, input logic [1:0] size,
                            input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
      req_valid_i  = v;
      req_wen_i    = wen;
      req_size_i   = size;
      req_signed_i = sgn;
      req_addr_i   = addr;
      req_wdata_i  = wd;
   endtask

   task automatic idle_inputs();
      drive_req(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
      mem_yumi_i   = 1'b0;
      mem_rvalid_i = 1'b0;
      commit_ok_i  = 1'b1;
   endtask

   task automatic single_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                              input logic sgn, input logic [31:0] rdata, input logic [31:0] exp);
      drive_req(1'b1, 1'b0, size, sgn, addr, 32'd0);
      sample(); check({tag, "_yumi"}, req_yumi_o, 1'b1); advance();
      req_valid_i = 1'b0;
      mem_yumi_i  = 1'b1;
      sample(); advance();
      mem_yumi_i   = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rdata;
      sample(); check({tag, "_rdv"}, rd_valid_o, 1'b1); check({tag, "_data"}, rd_data_o, exp); advance();
      mem_rvalid_i = 1'b0;
      sample(); check({tag, "_pulse"}, rd_valid_o, 1'b0); check({tag, "_stall"}, stall_o, 1'b0); advance();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n_yumi;
      int          k;
      logic [31:0] a;

      idle_inputs();
      do_reset(2);

      sample();
      check("rst_mem_valid", mem_valid_o, 1'b0);
      check("rst_rd_valid", rd_valid_o, 1'b0);
      check("rst_rd_data", rd_data_o, 32'd0);
      check("rst_exc", exc_o, 1'b0);
      check("rst_stall", stall_o, 1'b0);
      check("rst_state", 64'(dut.state), 64'(IDLE));
      advance();

      single_load("word_ld", 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
      single_load("sbyte_ld", 32'h103, 2'd0, 1'b1, 32'h80112233, 32'hFFFFFF80);
      single_load("ubyte_ld", 32'h103, 2'd0, 1'b0, 32'h80112233, 32'h00000080);
      single_load("shalf_ld", 32'h102, 2'd1, 1'b1, 32'h8001C0DE, 32'hFFFF8001);

      // Three back-to-back word loads with responses withheld.
      mem_yumi_i = 1'b1;
      k = 0;
      n_yumi = 0;
      drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'd0);
      for (int c = 0; c < 6; c++) begin
         sample();
         if (req_yumi_o) n_yumi++;
         advance();
         if (e_yumi && k < 2) begin
            k++;
            req_addr_i = 32'h200 + 32'(4 * k);
         end
      end
      check("full_yumi_count", n_yumi, 2);
      sample();
      check("full_state", 64'(dut.state), 64'(FULL));
      check("full_stall", stall_o, 1'b1);
      advance();

      // Response held off by commit_ok_i, then released.
      req_valid_i  = 1'b0;
      mem_yumi_i   = 1'b0;
      mem_rvalid_i = 1'b1;
      commit_ok_i  = 1'b0;
      mem_rdata_i  = 32'h11111111;
      for (int c = 0; c < 3; c++) begin
         sample();
         check("hold_ryumi", mem_ryumi_o, 1'b0);
         check("hold_cnt", 64'(dut.out_cnt), 64'd2);
         advance();
      end
      commit_ok_i = 1'b1;
      sample(); check("commit_rd0", rd_data_o, 32'h11111111); advance();
      mem_rdata_i = 32'h22222222;
      sample(); check("commit_rd1", rd_data_o, 32'h22222222); advance();
      mem_rvalid_i = 1'b0;
      sample(); check("drained_stall", stall_o, 1'b0); advance();

      // Byte store replication.
      drive_req(1'b1, 1'b1, 2'd0, 1'b0, 32'h2, 32'h123456A5);
      sample(); advance();
      req_valid_i = 1'b0;
      sample();
      check("st_wdata", mem_wdata_o, 32'hA5A5A5A5);
      check("st_size", mem_size_o, 2'd0);
      check("st_addr", mem_addr_o, 32'h2);
      advance();
      mem_yumi_i = 1'b1;
      sample(); advance();
      mem_yumi_i   = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hFFFFFFFF;
      sample(); check("st_retire", rd_valid_o, 1'b1); check("st_rd_zero", rd_data_o, 32'd0); advance();
      mem_rvalid_i = 1'b0;

      // Misaligned word load.
`ifdef LSU_MISALIGN_EXC_EN
      drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'd0);
      sample(); advance();
      req_valid_i = 1'b0;
      mem_yumi_i  = 1'b1;
      sample(); advance();
      mem_yumi_i = 1'b0;
      drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'd0);
      sample(); check("mis_no_yumi", req_yumi_o, 1'b0); check("mis_exc_pre", exc_o, 1'b0); advance();
      drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'd0);
      sample();
      check("mis_exc", exc_o, 1'b1);
      check("mis_state", 64'(dut.state), 64'(ERR));
      check("err_no_yumi", req_yumi_o, 1'b0);
      advance();
      req_valid_i  = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h0BADF00D;
      sample(); check("err_drain", rd_valid_o, 1'b1); check("err_drain_data", rd_data_o, 32'h0BADF00D); advance();
      mem_rvalid_i = 1'b0;
      do_reset(1);
`else
      drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'd0);
      sample(); check("trunc_yumi", req_yumi_o, 1'b1); advance();
      req_valid_i = 1'b0;
      sample(); check("trunc_addr", mem_addr_o, 32'h100); check("trunc_exc", exc_o, 1'b0); advance();
      mem_yumi_i = 1'b1;
      sample(); advance();
      mem_yumi_i   = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hCAFEF00D;
      sample(); check("trunc_data", rd_data_o, 32'hCAFEF00D); advance();
      mem_rvalid_i = 1'b0;
`endif

      // Reset with operations in flight; a late response must be ignored.
      drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'd0);
      mem_yumi_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         sample(); advance();
      end
      idle_inputs();
      do_reset(1);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h55AA55AA;
      sample();
      check("late_ryumi", mem_ryumi_o, 1'b0);
      check("late_rd_valid", rd_valid_o, 1'b0);
      check("late_cnt", 64'(dut.out_cnt), 64'd0);
      advance();
      idle_inputs();

      // Random traffic.
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            idle_inputs();
            do_reset(1);
         end
         a = $urandom();
`ifdef LSU_MISALIGN_EXC_EN
         a[1:0] = 2'b00;
`endif
         drive_req(($urandom_range(0, 9) < 6), $urandom_range(0, 1), 2'($urandom_range(0, 2)),
                   $urandom_range(0, 1), a, $urandom());
         mem_yumi_i   = ($urandom_range(0, 9) < 7);
         mem_rvalid_i = ($urandom_range(0, 9) < 6);
         commit_ok_i  = ($urandom_range(0, 3) != 0);
         mem_rdata_i  = $urandom();
         sample();
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
